// File: rtl/stack_controller_if.sv
// Command, response and data-memory handshake bundle for the stack controller.
// The controller connects through the slave modport; the core/memory side uses master.
interface stack_controller_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready, mem_rdata, mem_ack,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready, mem_rdata, mem_ack,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/stack_controller.sv
// Single owner of the full-descending stack pointer: serialises push/pop/load/read
// commands and drives one req/ack data-memory port, rejecting overflow/underflow.
//
// state   | meaning
// IDLE    | cmd_ready=1, waiting for a command
// MEM     | memory access in flight, mem_req=1 until mem_ack
// RESP    | rsp_valid=1, holding response until rsp_ready
module stack_controller #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] SP_RESET = 32'h0000_0999,
    parameter logic [AW-1:0] SP_LIMIT = 32'h0000_0900
) (
    input  logic                 clock_4,
    input  logic                 reset,
    stack_controller_if.slave    bus,
    output logic [AW-1:0]        stack_addr,
    output logic                 ovf_flag,
    output logic                 unf_flag
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    rst_sync;
    logic          rst_int_n;
    logic [AW-1:0] sp;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_we_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_err_q;
    logic          ovf_q;
    logic          unf_q;
    logic [AW-1:0] cmd_sp;
    logic          stack_full;
    logic          stack_empty;
    logic          load_ok;

    // Assert asynchronously, release on a clock edge so all state leaves reset together.
    always_ff @(posedge clock_4 or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync[1];

    assign cmd_sp      = AW'(bus.cmd_data);
    assign stack_full  = (sp == SP_LIMIT);
    assign stack_empty = (sp == SP_RESET);
    assign load_ok     = (cmd_sp >= SP_LIMIT) && (cmd_sp <= SP_RESET);

    always_ff @(posedge clock_4 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_PUSH: state_nxt = stack_full  ? ST_RESP : ST_MEM;
                        OP_POP:  state_nxt = stack_empty ? ST_RESP : ST_MEM;
                        default: state_nxt = ST_RESP;
                    endcase
                end
            end
            ST_MEM: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Limits are checked before any +-1, so SP can never leave [SP_LIMIT, SP_RESET].
    always_ff @(posedge clock_4 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sp          <= SP_RESET;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        rsp_err_q  <= 1'b0;
                        rsp_data_q <= '0;
                        case (bus.cmd_op)
                            OP_PUSH: begin
                                if (stack_full) begin
                                    rsp_err_q <= 1'b1;
                                    ovf_q     <= 1'b1;
                                end else begin
                                    mem_addr_q  <= sp - 1'b1;
                                    mem_wdata_q <= bus.cmd_data;
                                    mem_we_q    <= 1'b1;
                                end
                            end
                            OP_POP: begin
                                if (stack_empty) begin
                                    rsp_err_q <= 1'b1;
                                    unf_q     <= 1'b1;
                                end else begin
                                    mem_addr_q <= sp;
                                    mem_we_q   <= 1'b0;
                                end
                            end
                            OP_LOAD: begin
                                if (load_ok) begin
                                    sp         <= cmd_sp;
                                    ovf_q      <= 1'b0;
                                    unf_q      <= 1'b0;
                                    rsp_data_q <= bus.cmd_data;
                                end else begin
                                    rsp_err_q  <= 1'b1;
                                    rsp_data_q <= DW'(sp);
                                end
                            end
                            default: rsp_data_q <= DW'(sp);
                        endcase
                    end
                end
                ST_MEM: begin
                    if (bus.mem_ack) begin
                        if (mem_we_q) begin
                            sp <= sp - 1'b1;
                        end else begin
                            sp         <= sp + 1'b1;
                            rsp_data_q <= bus.mem_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign stack_addr    = sp;
    assign ovf_flag      = ovf_q;
    assign unf_flag      = unf_q;
endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller: reference model of SP/flags/memory,
// expected responses queued at issue time and compared at the response handshake.
module tb_stack_controller;
    localparam logic [31:0] SP_RESET = 32'h0000_0999;
    localparam logic [31:0] SP_LIMIT = 32'h0000_0900;
    localparam logic [1:0]  OP_PUSH  = 2'b00;
    localparam logic [1:0]  OP_POP   = 2'b01;
    localparam logic [1:0]  OP_LOAD  = 2'b10;
    localparam logic [1:0]  OP_READ  = 2'b11;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk_data;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic [31:0] stack_addr;
    logic        ovf_flag;
    logic        unf_flag;

    int          checks;
    int          failures;
    rsp_t        exp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] model_sp;
    logic        model_ovf;
    logic        model_unf;

    stack_controller_if #(.AW(32), .DW(32)) bus ();

    stack_controller dut (
        .clock_4    (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .stack_addr (stack_addr),
        .ovf_flag   (ovf_flag),
        .unf_flag   (unf_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] data,
                          input int ack_dly, input int rdy_dly, input bit stray);
        logic [31:0] sp0, addr, nsp, cap_d;
        logic        cap_e;
        bit          mem_op, we;
        rsp_t        e;
        int          n;
        sp0 = model_sp; nsp = sp0; mem_op = 0; we = 0; addr = '0;
        e.data = '0; e.err = 1'b0; e.chk_data = 1;
        case (op)
            OP_PUSH: if (sp0 == SP_LIMIT) begin
                         e.err = 1'b1; e.chk_data = 0; model_ovf = 1'b1;
                     end else begin
                         mem_op = 1; we = 1; addr = sp0 - 1; nsp = sp0 - 1;
                     end
            OP_POP:  if (sp0 == SP_RESET) begin
                         e.err = 1'b1; e.chk_data = 0; model_unf = 1'b1;
                     end else begin
                         mem_op = 1; we = 0; addr = sp0; nsp = sp0 + 1;
                         e.data = mem_model.exists(addr) ? mem_model[addr] : 32'h0;
                     end
            OP_LOAD: if (data >= SP_LIMIT && data <= SP_RESET) begin
                         nsp = data; model_ovf = 1'b0; model_unf = 1'b0; e.data = data;
                     end else begin
                         e.err = 1'b1; e.chk_data = 0;
                     end
            default: e.data = sp0;
        endcase
        exp_q.push_back(e);

        bus.cmd_op = op; bus.cmd_data = data; bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'($urandom); bus.cmd_data = $urandom;

        if (mem_op) begin
            chk("mem_req", bus.mem_req, 1);
            chk("mem_we", bus.mem_we, we);
            chk("mem_addr", bus.mem_addr, addr);
            if (we) chk("mem_wdata", bus.mem_wdata, data);
            chk("cmd_ready_mem", bus.cmd_ready, 0);
            chk("sp_before_ack", stack_addr, sp0);
            for (int i = 0; i < ack_dly; i++) begin
                if (stray && i == 0) begin
                    bus.cmd_valid = 1'b1; bus.cmd_op = OP_READ; bus.cmd_data = $urandom;
                end
                @(negedge clk);
                chk("mem_req_hold", bus.mem_req, 1);
                chk("mem_addr_hold", bus.mem_addr, addr);
                if (we) chk("mem_wdata_hold", bus.mem_wdata, data);
                chk("sp_wait_ack", stack_addr, sp0);
                chk("cmd_ready_wait", bus.cmd_ready, 0);
            end
            bus.mem_ack = 1'b1;
            bus.mem_rdata = we ? $urandom : e.data;
            if (we) mem_model[addr] = data;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            chk("sp_after_ack", stack_addr, nsp);
        end else begin
            chk("no_mem_req", bus.mem_req, 0);
            chk("sp_no_mem", stack_addr, nsp);
        end
        model_sp = nsp;

        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("rsp_timeout", 32'(n < 20), 32'd1);
        cap_d = bus.rsp_data; cap_e = bus.rsp_err;
        for (int i = 0; i < rdy_dly; i++) begin
            if (stray) bus.mem_ack = 1'b1;
            @(negedge clk);
            chk("rsp_valid_hold", bus.rsp_valid, 1);
            chk("rsp_data_hold", bus.rsp_data, cap_d);
            chk("rsp_err_hold", bus.rsp_err, cap_e);
            chk("sp_resp", stack_addr, nsp);
            chk("mem_req_resp", bus.mem_req, 0);
        end
        bus.mem_ack = 1'b0;
        bus.rsp_ready = 1'b1;
        e = exp_q.pop_front();
        chk("rsp_err", bus.rsp_err, e.err);
        if (e.chk_data) chk("rsp_data", bus.rsp_data, e.data);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_clr", bus.rsp_valid, 0);
        chk("rsp_err_clr", bus.rsp_err, 0);
        chk("ovf_flag", ovf_flag, model_ovf);
        chk("unf_flag", unf_flag, model_unf);
        chk("sp_final", stack_addr, model_sp);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] rdata;
        checks = 0; failures = 0;
        model_sp = SP_RESET; model_ovf = 1'b0; model_unf = 1'b0;
        reset = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = '0;
        bus.rsp_ready = 1'b0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_sp", stack_addr, SP_RESET);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_flags", {30'd0, ovf_flag, unf_flag}, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", bus.cmd_ready, 1);

        // Push then pop with zero-wait ack.
        do_cmd(OP_PUSH, 32'hDEAD_BEEF, 0, 0, 0);
        do_cmd(OP_POP, 32'h0, 0, 0, 0);
        // Underflow on empty stack.
        do_cmd(OP_POP, 32'h0, 0, 0, 0);
        // Load to the limit, overflow, then an out-of-range load.
        do_cmd(OP_LOAD, 32'h0000_0900, 0, 0, 0);
        do_cmd(OP_PUSH, 32'h0000_1234, 0, 0, 0);
        do_cmd(OP_LOAD, 32'h0000_1000, 0, 0, 0);

        // Reset asserted while a pop is waiting for its ack.
        bus.cmd_op = OP_POP; bus.cmd_data = '0; bus.cmd_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("pre_rst_mem_req", bus.mem_req, 1);
        chk("pre_rst_mem_addr", bus.mem_addr, 32'h0000_0900);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_sp", stack_addr, SP_RESET);
        chk("midrst_mem_req", bus.mem_req, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_ovf", ovf_flag, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        model_sp = SP_RESET; model_ovf = 1'b0; model_unf = 1'b0;
        exp_q.delete();
        chk("post_midrst_rsp", bus.rsp_valid, 0);

        // Slow memory and slow response consumer.
        do_cmd(OP_PUSH, 32'hCAFE_F00D, 5, 3, 0);
        do_cmd(OP_PUSH, 32'h5555_AAAA, 1, 0, 0);
        do_cmd(OP_POP, 32'h0, 5, 3, 0);
        do_cmd(OP_POP, 32'h0, 2, 1, 0);

        // Stray acks while idle.
        bus.mem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_idle_req", bus.mem_req, 0);
            chk("stray_idle_rsp", bus.rsp_valid, 0);
            chk("stray_idle_sp", stack_addr, model_sp);
        end
        bus.mem_ack = 1'b0;
        @(negedge clk);
        // Command offered during MEM, stray acks during RESP; the offered read follows.
        do_cmd(OP_PUSH, 32'h0BAD_F00D, 2, 2, 1);
        do_cmd(OP_READ, 32'h0, 0, 1, 0);

        for (int k = 0; k < 12; k++) begin
            rop = 2'($urandom_range(0, 3));
            rdata = (rop == OP_LOAD) ? 32'($urandom_range(32'h8F0, 32'hA10)) : $urandom;
            do_cmd(rop, rdata, $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
